alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Command front-end and result register for the 8-bit combinational ALU. Accepts operand/opcode commands over a valid/ready handshake into a small command FIFO and drives the FIFO head onto the ALU inputs. It captures the ALU result into an output register that has its own valid/ready handshake. It can optionally forward the previous result as operand A, so dependent operation chains can be built.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥ 2
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- in_valid_i  in  1  command valid
- in_ready_o  out  1  FIFO can accept a command
- a_i  in  8  operand A
- b_i  in  8  operand B
- op_i  in  3  opcode: ADD=0, SUB, SLL, LSR, AND, OR, XOR, EQL=7
- use_prev_i  in  1  replace A with the previous result (forwarding build only)
- alu_a_o  out  8  ALU operand A (combinational from FIFO head)
- alu_b_o  out  8  ALU operand B
- alu_op_o  out  3  ALU opcode
- alu_res_i  in  8  ALU result, same cycle as alu_*_o
- out_valid_o  out  1  result register holds a result
- out_ready_i  in  1  consumer accepts result
- res_o  out  8  registered result
- res_op_o  out  3  opcode that produced res_o
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Push: on in_valid_i && in_ready_o. in_ready_o = (count_o != DEPTH), so it depends on occupancy only, never on out_ready_i.
- FIFO head drives alu_a_o/alu_b_o/alu_op_o. When the FIFO is empty, these outputs drive 0.
- Output register FSM has two states, EMPTY and FULL.
  - EMPTY → FULL: FIFO not empty. The stage captures alu_res_i and the head opcode, then pops.
  - FULL → FULL (new data): out_ready_i && FIFO not empty. Capture and pop in the same cycle.
  - FULL → EMPTY: out_ready_i && FIFO empty.
  - FULL && !out_ready_i: hold res_o and res_op_o and do not pop.
- Simultaneous push and pop: count_o is unchanged. When the FIFO is full, push is blocked even if a pop occurs in that cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count_o is tracked separately.
- All arithmetic is 8-bit, and wrap/truncation are owned by the ALU. This block does no width extension.
- prev_res register: loaded with alu_res_i on every capture, and independent of out_ready_i.
- Reset values:
  - in_ready_o = 1, out_valid_o = 0
  - res_o = 0, res_op_o = 0, count_o = 0
  - prev_res = 0, FSM = EMPTY, pointers = 0
- Reset mid-operation: all queued and held commands and results are discarded. No output glitches to valid.

## Timing
- Latency: a command accepted at edge k is captured at edge k+1. out_valid_o is high after edge k+1.
- Sustained throughput is 1 command/cycle when out_ready_i is held high.
- Backpressure: with out_ready_i low, the FIFO fills. in_ready_o drops in the cycle after the DEPTH-th push.
- The alu_*_o → alu_res_i path is a single combinational cycle. There is no register in between.
- out_valid_o, res_o, res_op_o and count_o are registered outputs. in_ready_o derives from registered count only.

## Configuration
- ALU_ISSUE_FWD_EN defined:
  - use_prev_i is stored per FIFO entry.
  - When the head entry's flag is set, alu_a_o = prev_res instead of the stored A. prev_res is the result of the last captured command.
- ALU_ISSUE_FWD_EN undefined:
  - use_prev_i is ignored and not stored.
  - alu_a_o is always the stored A.
  - The prev_res register is not instantiated.

## Structure
- Shared package alu_pkg holds:
  - alu_op_e enum (3-bit, ADD..EQL)
  - alu_cmd_t struct (a, b, op, plus use_prev under ALU_ISSUE_FWD_EN)
  - out FSM state enum
- Sub-module alu_cmd_fifo: a generic DEPTH-entry FIFO of alu_cmd_t with push/pop/full/empty/count.
- The top level contains the output FSM, the result register and the forwarding mux.

## Test plan
- Single ADD a=0x0F b=0x01, out_ready_i=1 → out_valid_o one cycle after accept, res_o=0x10, res_op_o=0.
- SUB a=0x00 b=0x01 → res_o=0xFF (wrap). EQL a=0x5A b=0x5A → 0x01. EQL a=0x5A b=0x5B → 0x00.
- Backpressure, out_ready_i=0, 5 back-to-back pushes (DEPTH=4):
  - 1st command captured into res; 4 more fill the FIFO; in_ready_o=0 with count_o=4.
  - Then raise out_ready_i → results are returned in push order, one per cycle.
- Streaming 16 commands with out_ready_i=1 → one result per cycle, no bubbles, count_o ≤ 1.
- Forwarding (ALU_ISSUE_FWD_EN): ADD 0x03+0x04, then ADD use_prev=1 b=0x10, then SLL use_prev=1 b=0x01 → results 0x07, 0x17, 0x2E.
- Reset asserted with FIFO at count 3 and out_valid_o=1 → all outputs at reset values immediately. After release, first new ADD 0x01+0x01 → res_o=0x02.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: opcodes, queued command and output FSM state.
// The command carries a use_prev flag only when ALU_ISSUE_FWD_EN is defined.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_SLL = 3'd2,
        OP_LSR = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_XOR = 3'd6,
        OP_EQL = 3'd7
    } alu_op_e;

    typedef struct packed {
`ifdef ALU_ISSUE_FWD_EN
        logic       use_prev;
`endif
        logic [7:0] a;
        logic [7:0] b;
        alu_op_e    op;
    } alu_cmd_t;

    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    localparam int       CMD_W         = $bits(alu_cmd_t);
    localparam alu_cmd_t ALU_CMD_RESET = alu_cmd_t'({CMD_W{1'b0}});

endpackage

// File: rtl/alu_cmd_fifo.sv
// DEPTH-entry command FIFO; the head entry is visible combinationally on rdata.
// Occupancy is tracked in its own counter so full/empty need no pointer MSB trick.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  alu_cmd_t                 wdata,
    output alu_cmd_t                 rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    alu_cmd_t        mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            do_push_s;
    logic            do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign rdata     = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= ALU_CMD_RESET;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: command FIFO feeding an external combinational ALU, plus result register.
// Define ALU_ISSUE_FWD_EN to let a command take the previous result as operand A.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [7:0]               a_i,
    input  logic [7:0]               b_i,
    input  logic [2:0]               op_i,
    input  logic                     use_prev_i,
    output logic [7:0]               alu_a_o,
    output logic [7:0]               alu_b_o,
    output logic [2:0]               alu_op_o,
    input  logic [7:0]               alu_res_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [7:0]               res_o,
    output logic [2:0]               res_op_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    alu_cmd_t    wcmd_s;
    alu_cmd_t    head_s;
    logic        full_s;
    logic        empty_s;
    logic        push_s;
    logic        capture_s;
    out_state_e  state_r;
    out_state_e  state_nxt_s;
    logic        valid_r;
    logic [7:0]  res_r;
    logic [2:0]  res_op_r;

    assign in_ready_o = !full_s;
    assign push_s     = in_valid_i && !full_s;

    // Pack the incoming command; the forwarding flag exists only in the forwarding build.
    always_comb begin
        wcmd_s    = ALU_CMD_RESET;
        wcmd_s.a  = a_i;
        wcmd_s.b  = b_i;
        wcmd_s.op = alu_op_e'(op_i);
`ifdef ALU_ISSUE_FWD_EN
        wcmd_s.use_prev = use_prev_i;
`endif
    end

`ifndef ALU_ISSUE_FWD_EN
    logic unused_use_prev_s;
    assign unused_use_prev_s = use_prev_i;
`endif

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push_s),
        .pop   (capture_s),
        .wdata (wcmd_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_o)
    );

`ifdef ALU_ISSUE_FWD_EN
    logic [7:0] prev_res_r;

    // Last captured result, kept regardless of whether the consumer has taken it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_res_r <= 8'h00;
        end else if (capture_s) begin
            prev_res_r <= alu_res_i;
        end else begin
            prev_res_r <= prev_res_r;
        end
    end
`endif

    // Drive the ALU from the FIFO head, zeros when nothing is queued.
    always_comb begin
        alu_a_o  = 8'h00;
        alu_b_o  = 8'h00;
        alu_op_o = 3'd0;
        if (empty_s) begin
            alu_a_o  = 8'h00;
            alu_b_o  = 8'h00;
            alu_op_o = 3'd0;
        end else begin
`ifdef ALU_ISSUE_FWD_EN
            alu_a_o = head_s.use_prev ? prev_res_r : head_s.a;
`else
            alu_a_o = head_s.a;
`endif
            alu_b_o  = head_s.b;
            alu_op_o = head_s.op;
        end
    end

    // Output register FSM: capture whenever the register is free or being drained.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        case (state_r)
            OUT_EMPTY: begin
                if (!empty_s) begin
                    capture_s   = 1'b1;
                    state_nxt_s = OUT_FULL;
                end else begin
                    state_nxt_s = OUT_EMPTY;
                end
            end
            OUT_FULL: begin
                if (out_ready_i) begin
                    if (!empty_s) begin
                        capture_s   = 1'b1;
                        state_nxt_s = OUT_FULL;
                    end else begin
                        state_nxt_s = OUT_EMPTY;
                    end
                end else begin
                    state_nxt_s = OUT_FULL;
                end
            end
            default: begin
                capture_s   = 1'b0;
                state_nxt_s = OUT_EMPTY;
            end
        endcase
    end

    // State, valid flag and result register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r  <= OUT_EMPTY;
            valid_r  <= 1'b0;
            res_r    <= 8'h00;
            res_op_r <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            valid_r <= (state_nxt_s == OUT_FULL);
            if (capture_s) begin
                res_r    <= alu_res_i;
                res_op_r <= alu_op_o;
            end else begin
                res_r    <= res_r;
                res_op_r <= res_op_r;
            end
        end
    end

    assign out_valid_o = valid_r;
    assign res_o       = res_r;
    assign res_op_o    = res_op_r;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage; a small ALU model closes the loop.
// Forwarding vectors run when ALU_ISSUE_FWD_EN is defined.
module tb_alu_issue_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       use_prev;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_res;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] res;
    logic [2:0] res_op;
    logic [2:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    alu_issue_stage #(.DEPTH(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .op_i        (op),
        .use_prev_i  (use_prev),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .alu_op_o    (alu_op),
        .alu_res_i   (alu_res),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .res_o       (res),
        .res_op_o    (res_op),
        .count_o     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [7:0] x, input logic [7:0] y,
                                             input logic [2:0] o);
        case (o)
            3'd0:    return x + y;
            3'd1:    return x - y;
            3'd2:    return x << y;
            3'd3:    return x >> y;
            3'd4:    return x & y;
            3'd5:    return x | y;
            3'd6:    return x ^ y;
            default: return (x == y) ? 8'h01 : 8'h00;
        endcase
    endfunction

    always_comb alu_res = alu_model(alu_a, alu_b, alu_op);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic v, input logic [2:0] o, input logic [7:0] x,
                           input logic [7:0] y, input logic up);
        in_valid = v;
        op       = o;
        a        = x;
        b        = y;
        use_prev = up;
    endtask

    // Push one command with the consumer ready, then check the captured result.
    task automatic one_cmd(input string tag, input logic [2:0] o, input logic [7:0] x,
                           input logic [7:0] y, input logic [7:0] exp_res);
        out_ready = 1'b1;
        set_cmd(1'b1, o, x, y, 1'b0);
        tick();
        set_cmd(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        chk({tag, "_pre_valid"}, out_valid, 1'b0);
        chk({tag, "_pre_count"}, count, 3'd1);
        tick();
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_res"}, res, exp_res);
        chk({tag, "_op"}, res_op, o);
        chk({tag, "_count"}, count, 3'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        set_cmd(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_res", res, 8'h00);
        chk("rst_res_op", res_op, 3'd0);
        chk("rst_count", count, 3'd0);
        chk("rst_alu_a", alu_a, 8'h00);
        rst_n = 1'b1;
        tick();

        // Single operations and boundary values.
        one_cmd("add", 3'd0, 8'h0F, 8'h01, 8'h10);
        one_cmd("sub_wrap", 3'd1, 8'h00, 8'h01, 8'hFF);
        one_cmd("eql_eq", 3'd7, 8'h5A, 8'h5A, 8'h01);
        one_cmd("eql_ne", 3'd7, 8'h5A, 8'h5B, 8'h00);
        one_cmd("lsr", 3'd3, 8'h80, 8'h03, 8'h10);
        one_cmd("xor", 3'd6, 8'hF0, 8'hFF, 8'h0F);
        tick();
        chk("idle_valid", out_valid, 1'b0);

        // Backpressure: five pushes, first lands in the result register, four fill the FIFO.
        out_ready = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            set_cmd(1'b1, 3'd0, 8'(j), 8'h20, 1'b0);
            tick();
        end
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_count", count, 3'd4);
        chk("bp_valid", out_valid, 1'b1);
        chk("bp_res_first", res, 8'h21);
        set_cmd(1'b1, 3'd5, 8'h99, 8'h99, 1'b0);
        tick();
        chk("bp_blocked_count", count, 3'd4);
        chk("bp_hold_res", res, 8'h21);
        chk("bp_head_a", alu_a, 8'h02);
        set_cmd(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        out_ready = 1'b1;
        for (int j = 2; j <= 5; j++) begin
            tick();
            chk("bp_drain_valid", out_valid, 1'b1);
            chk("bp_drain_res", res, 8'(8'h20 + j));
            chk("bp_drain_count", count, 3'(5 - j));
        end
        tick();
        chk("bp_done_valid", out_valid, 1'b0);
        chk("bp_done_ready", in_ready, 1'b1);

        // Streaming: one result per cycle with occupancy never above one.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_cmd(1'b1, 3'd5, 8'(i), 8'h80, 1'b0);
            tick();
            chk("st_count", count, 3'd1);
            if (i > 0) begin
                chk("st_valid", out_valid, 1'b1);
                chk("st_res", res, 8'(8'h80 | (i - 1)));
            end
        end
        set_cmd(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        tick();
        chk("st_last_res", res, 8'h8F);
        chk("st_last_op", res_op, 3'd5);
        chk("st_last_count", count, 3'd0);
        tick();

`ifdef ALU_ISSUE_FWD_EN
        // Forwarding chain: 3+4, prev+0x10, prev<<1.
        out_ready = 1'b1;
        set_cmd(1'b1, 3'd0, 8'h03, 8'h04, 1'b0);
        tick();
        set_cmd(1'b1, 3'd0, 8'h00, 8'h10, 1'b1);
        tick();
        chk("fwd_r0", res, 8'h07);
        set_cmd(1'b1, 3'd2, 8'h00, 8'h01, 1'b1);
        tick();
        chk("fwd_r1", res, 8'h17);
        set_cmd(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        tick();
        chk("fwd_r2", res, 8'h2E);
        chk("fwd_r2_op", res_op, 3'd2);
        tick();
`else
        // Without forwarding the flag is ignored and the stored A is used.
        out_ready = 1'b1;
        set_cmd(1'b1, 3'd0, 8'h05, 8'h01, 1'b1);
        tick();
        set_cmd(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        chk("nofwd_alu_a", alu_a, 8'h05);
        tick();
        chk("nofwd_res", res, 8'h06);
        tick();
`endif

        // Reset mid-operation with three queued and one held result.
        out_ready = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            set_cmd(1'b1, 3'd4, 8'hFF, 8'(j), 1'b0);
            tick();
        end
        set_cmd(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        chk("mr_pre_count", count, 3'd3);
        chk("mr_pre_valid", out_valid, 1'b1);
        chk("mr_pre_res", res, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("mr_count", count, 3'd0);
        chk("mr_valid", out_valid, 1'b0);
        chk("mr_res", res, 8'h00);
        chk("mr_res_op", res_op, 3'd0);
        chk("mr_in_ready", in_ready, 1'b1);
        tick();
        chk("mr_hold_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        tick();
        one_cmd("post_rst_add", 3'd0, 8'h01, 8'h01, 8'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
